// File: rtl/mem_arbiter.sv
// Two-master arbiter for the 256-byte program/data memory: the CPU owns it by
// default, and a loader/debug master borrows it through valid/ready in bounded bursts.
module mem_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cpu_R,
    input  logic       i_cpu_W,
    input  logic [7:0] i_cpu_addr,
    input  logic [7:0] i_cpu_wdata,
    output logic [7:0] o_cpu_rdata,
    output logic       o_cpu_stall,
    input  logic       i_ld_req,
    input  logic       i_ld_we,
    input  logic [7:0] i_ld_addr,
    input  logic [7:0] i_ld_wdata,
    output logic       o_ld_gnt,
    output logic [7:0] o_ld_rdata,
    output logic       o_mem_R,
    output logic       o_mem_W,
    output logic [7:0] o_mem_addr,
    output logic [7:0] o_mem_wdata,
    input  logic [7:0] i_mem_rdata,
    output logic       o_err,
    output logic       o_owner
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

    typedef enum logic {
        CPU_OWN = 1'b0,
        LD_OWN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_burst_cnt;
    logic [7:0]    r_ld_rdata;
    logic          r_err;
    logic          w_xfer;
    logic          w_cpu_pend;
    logic          w_collide;

    assign w_xfer     = (r_state == LD_OWN) & i_ld_req;
    assign w_cpu_pend = ~i_cpu_R | ~i_cpu_W;
    assign w_collide  = ~i_cpu_R & ~i_cpu_W;

    assign o_owner    = r_state;
    assign o_ld_rdata = r_ld_rdata;
    assign o_err      = r_err;

    // Owner state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= CPU_OWN;
        end else begin
            r_state <= w_next;
        end
    end

    // Next owner and the owner-selected memory/port mux.
    always_comb begin
        w_next      = r_state;
        o_mem_R     = 1'b1;
        o_mem_W     = 1'b1;
        o_mem_addr  = i_cpu_addr;
        o_mem_wdata = i_cpu_wdata;
        o_cpu_rdata = 8'h00;
        o_cpu_stall = 1'b0;
        o_ld_gnt    = 1'b0;
        case (r_state)
            CPU_OWN: begin
                // A read+write collision blocks both strobes.
                o_mem_R     = i_cpu_R | w_collide;
                o_mem_W     = i_cpu_W | w_collide;
                o_mem_addr  = i_cpu_addr;
                o_mem_wdata = i_cpu_wdata;
                o_cpu_rdata = i_mem_rdata;
                if (i_ld_req) begin
                    w_next = LD_OWN;
                end else begin
                    w_next = CPU_OWN;
                end
            end
            LD_OWN: begin
                o_mem_R     = ~(i_ld_req & ~i_ld_we);
                o_mem_W     = ~(i_ld_req & i_ld_we);
                o_mem_addr  = i_ld_addr;
                o_mem_wdata = i_ld_wdata;
                o_cpu_rdata = 8'h00;
                o_cpu_stall = 1'b1;
                o_ld_gnt    = 1'b1;
                if (!i_ld_req) begin
                    w_next = CPU_OWN;
                end else if ((r_burst_cnt == LAST) && w_cpu_pend) begin
                    w_next = CPU_OWN;
                end else begin
                    w_next = LD_OWN;
                end
            end
            default: begin
                w_next = CPU_OWN;
            end
        endcase
    end

    // Burst counter: cleared on loader entry, saturates so a late CPU request wins next transfer.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_burst_cnt <= {CW{1'b0}};
        end else if ((r_state == CPU_OWN) && (w_next == LD_OWN)) begin
            r_burst_cnt <= {CW{1'b0}};
        end else if (w_xfer && (r_burst_cnt != LAST)) begin
            r_burst_cnt <= r_burst_cnt + CW'(1);
        end else begin
            r_burst_cnt <= r_burst_cnt;
        end
    end

    // Loader read data capture at each loader read transfer.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ld_rdata <= 8'h00;
        end else if (w_xfer && !i_ld_we) begin
            r_ld_rdata <= i_mem_rdata;
        end else begin
            r_ld_rdata <= r_ld_rdata;
        end
    end

    // Sticky collision flag, independent of owner.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_err <= 1'b0;
        end else if (w_collide) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected transfers and
// per-cycle state; a monitor compares them mid-cycle against a memory model.
module tb_mem_arbiter;

    localparam int K_OWNER = 0, K_STALL = 1, K_GNT = 2, K_CPURD = 3, K_ERR = 4;
    localparam int K_LDRD = 5, K_MEMR = 6, K_MEMW = 7, K_MEM = 8, K_IDX = 9;

    typedef struct { int k; logic [7:0] a; logic [7:0] e; } sc_t;
    typedef struct { logic we; logic [7:0] a; logic [7:0] d; } xf_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_R, cpu_W;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       cpu_stall;
    logic       ld_req, ld_we, ld_gnt;
    logic [7:0] ld_addr, ld_wdata, ld_rdata;
    logic       mem_R, mem_W;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       err, owner;

    logic [7:0] mem [256];
    logic       mem_init;
    sc_t        sc_q[$];
    xf_t        xf_q[$];
    int         ld_idx;
    int         checks = 0;
    int         errors = 0;

    mem_arbiter #(.MAX_BURST(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_R(cpu_R), .i_cpu_W(cpu_W), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
        .i_ld_req(ld_req), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata),
        .o_ld_gnt(ld_gnt), .o_ld_rdata(ld_rdata),
        .o_mem_R(mem_R), .o_mem_W(mem_W), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_err(err), .o_owner(owner)
    );

    always #5 clk = ~clk;

    // Memory model: asynchronous read while mem_R low, write at the edge while mem_W low.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (!mem_W) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = (!mem_R) ? mem[mem_addr] : 8'h00;

    function automatic logic [7:0] actual(int k, logic [7:0] a);
        case (k)
            K_OWNER: return {7'b0, owner};
            K_STALL: return {7'b0, cpu_stall};
            K_GNT:   return {7'b0, ld_gnt};
            K_CPURD: return cpu_rdata;
            K_ERR:   return {7'b0, err};
            K_LDRD:  return ld_rdata;
            K_MEMR:  return {7'b0, mem_R};
            K_MEMW:  return {7'b0, mem_W};
            K_MEM:   return mem[a];
            K_IDX:   return ld_idx[7:0];
            default: return 8'hEE;
        endcase
    endfunction

    function automatic string kname(int k);
        case (k)
            K_OWNER: return "owner";
            K_STALL: return "cpu_stall";
            K_GNT:   return "ld_gnt";
            K_CPURD: return "cpu_rdata";
            K_ERR:   return "err";
            K_LDRD:  return "ld_rdata";
            K_MEMR:  return "mem_R";
            K_MEMW:  return "mem_W";
            K_MEM:   return "memory";
            K_IDX:   return "transfers_done";
            default: return "unknown";
        endcase
    endfunction

    task automatic cmp(string nm, logic [7:0] a, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%02h t=%0t actual=%02h expected=%02h", nm, a, $time, act, exp);
        end
    endtask

    // Monitor: mid-cycle (and just after an asynchronous reset) compare queued expectations.
    always begin
        logic       pend_rd;
        logic [7:0] pend_val;
        xf_t        x;
        sc_t        s;
        pend_rd = 1'b0;
        pend_val = 8'h00;
        forever begin
            @(negedge clk or negedge rst);
            #1;
            if (rst === 1'b1) begin
                if (pend_rd) begin
                    cmp("ld_rdata_after_read", 8'h00, ld_rdata, pend_val);
                    pend_rd = 1'b0;
                end
                if (ld_req && ld_gnt) begin
                    if (xf_q.size() == 0) begin
                        cmp("unexpected_transfer", mem_addr, 8'h01, 8'h00);
                    end else begin
                        x = xf_q.pop_front();
                        cmp("xfer_addr", x.a, mem_addr, x.a);
                        if (x.we) begin
                            cmp("xfer_mem_W", x.a, {7'b0, mem_W}, 8'h00);
                            cmp("xfer_wdata", x.a, mem_wdata, x.d);
                        end else begin
                            cmp("xfer_mem_R", x.a, {7'b0, mem_R}, 8'h00);
                            pend_rd = 1'b1;
                            pend_val = x.d;
                        end
                    end
                end
            end
            while (sc_q.size() != 0) begin
                s = sc_q.pop_front();
                cmp(kname(s.k), s.a, actual(s.k, s.a), s.e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(int k, logic [7:0] a, logic [7:0] e);
        sc_q.push_back('{k: k, a: a, e: e});
    endtask

    task automatic xf(logic we, logic [7:0] a, logic [7:0] d);
        xf_q.push_back('{we: we, a: a, d: d});
    endtask

    // Loader write stream with a real handshake; pat bit c is the expected owner in cycle c.
    task automatic ld_stream(logic [7:0] a0, logic [7:0] d0, int n, logic [63:0] pat, logic cpu_pend);
        int  cyc;
        int  pushed;
        logic took;
        ld_idx = 0;
        cyc = 0;
        pushed = -1;
        while (ld_idx < n && cyc < 64) begin
            ld_req = 1'b1;
            ld_we = 1'b1;
            ld_addr = a0 + 8'(ld_idx);
            ld_wdata = d0 + 8'(ld_idx);
            if (pushed != ld_idx) begin
                xf(1'b1, ld_addr, ld_wdata);
                pushed = ld_idx;
            end
            chk(K_OWNER, 8'h00, {7'b0, pat[cyc]});
            if (pat[cyc]) begin
                chk(K_STALL, 8'h00, 8'h01);
                chk(K_CPURD, 8'h00, 8'h00);
            end else if (cpu_pend) begin
                chk(K_STALL, 8'h00, 8'h00);
                chk(K_CPURD, 8'h10, 8'h3C);
            end else begin
                chk(K_STALL, 8'h00, 8'h00);
            end
            took = ld_gnt;
            step();
            cyc++;
            if (took) ld_idx++;
        end
        ld_req = 1'b0;
        chk(K_IDX, 8'h00, 8'(n));
        chk(K_OWNER, 8'h00, 8'h01);
        step();
        chk(K_OWNER, 8'h00, 8'h00);
        chk(K_GNT, 8'h00, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; mem_init = 1'b1; ld_idx = 0;
        cpu_R = 1'b1; cpu_W = 1'b1; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = 8'h00; ld_wdata = 8'h00;
        step(); step();
        chk(K_OWNER, 8'h00, 8'h00); chk(K_STALL, 8'h00, 8'h00); chk(K_GNT, 8'h00, 8'h00);
        chk(K_ERR, 8'h00, 8'h00); chk(K_LDRD, 8'h00, 8'h00); chk(K_MEMR, 8'h00, 8'h01);
        step();
        rst = 1'b1; mem_init = 1'b0;

        // CPU pass-through write, read back, overwrite.
        step(); cpu_W = 1'b0; cpu_addr = 8'h10; cpu_wdata = 8'hA5; chk(K_MEMW, 8'h00, 8'h00);
        step(); cpu_W = 1'b1; cpu_R = 1'b0;
        chk(K_CPURD, 8'h10, 8'hA5); chk(K_STALL, 8'h00, 8'h00); chk(K_OWNER, 8'h00, 8'h00);
        step(); cpu_R = 1'b1; cpu_W = 1'b0; cpu_wdata = 8'h3C;
        step(); cpu_W = 1'b1; chk(K_MEM, 8'h10, 8'h3C);

        // Loader single write then read.
        step(); ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h80; ld_wdata = 8'h77;
        xf(1'b1, 8'h80, 8'h77); chk(K_GNT, 8'h00, 8'h00); chk(K_OWNER, 8'h00, 8'h00);
        step(); chk(K_GNT, 8'h00, 8'h01); chk(K_STALL, 8'h00, 8'h01); chk(K_CPURD, 8'h00, 8'h00);
        step(); ld_we = 1'b0; xf(1'b0, 8'h80, 8'h77); chk(K_MEM, 8'h80, 8'h77);
        step(); ld_req = 1'b0; chk(K_OWNER, 8'h00, 8'h01); chk(K_LDRD, 8'h00, 8'h77);
        step(); chk(K_OWNER, 8'h00, 8'h00); chk(K_GNT, 8'h00, 8'h00);

        // Fairness: CPU read pending throughout, 10 loader writes -> 4, yield, 4, yield, 2.
        step(); cpu_R = 1'b0; cpu_addr = 8'h10;
        ld_stream(8'h00, 8'h20, 10, 64'h0000_0000_0000_1BDE, 1'b1);
        cpu_R = 1'b1;
        for (int i = 0; i < 10; i++) chk(K_MEM, 8'(i), 8'h20 + 8'(i));

        // Idle CPU: 20 loader writes without a yield.
        step();
        ld_stream(8'h40, 8'h60, 20, 64'h0000_0000_001F_FFFE, 1'b0);
        chk(K_MEM, 8'h40, 8'h60); chk(K_MEM, 8'h53, 8'h73);

        // Collision: both strobes blocked, no write, sticky err.
        step(); cpu_R = 1'b0; cpu_W = 1'b0; cpu_addr = 8'h10; cpu_wdata = 8'hFF;
        chk(K_MEMR, 8'h00, 8'h01); chk(K_MEMW, 8'h00, 8'h01); chk(K_ERR, 8'h00, 8'h00);
        step(); cpu_R = 1'b1; cpu_W = 1'b1; chk(K_ERR, 8'h00, 8'h01); chk(K_MEM, 8'h10, 8'h3C);
        step(); step(); chk(K_ERR, 8'h00, 8'h01);

        // Reset in the middle of the second of four loader writes.
        step(); ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h90; ld_wdata = 8'hD0;
        xf(1'b1, 8'h90, 8'hD0); chk(K_OWNER, 8'h00, 8'h00);
        step(); chk(K_OWNER, 8'h00, 8'h01);
        step(); ld_addr = 8'h91; ld_wdata = 8'hD1; xf(1'b1, 8'h91, 8'hD1); chk(K_GNT, 8'h00, 8'h01);
        @(negedge clk); #3;
        chk(K_OWNER, 8'h00, 8'h00); chk(K_GNT, 8'h00, 8'h00); chk(K_STALL, 8'h00, 8'h00);
        rst = 1'b0;
        step(); step();
        ld_req = 1'b0; rst = 1'b1;
        chk(K_ERR, 8'h00, 8'h00); chk(K_LDRD, 8'h00, 8'h00); chk(K_OWNER, 8'h00, 8'h00);
        chk(K_MEM, 8'h90, 8'hD0); chk(K_MEM, 8'h91, 8'h00);
        step(); step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter for the 256-byte program/data memory. It sits between `dCPU`'s memory port and the memory, and shares the memory with a loader/debug master (program loader, debugger peek/poke). The CPU owns memory by default. The loader takes memory through a valid/ready handshake and holds it for bounded bursts, and the CPU is stalled while it waits. The block also flags illegal simultaneous CPU read+write strobes.

## Interface
- `MAX_BURST`, 4: number of consecutive loader transfers after which the loader must yield to a pending CPU access (≥1).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cpu_R`  in  1  CPU read strobe, active low.
- `cpu_W`  in  1  CPU write strobe, active low.
- `cpu_addr`  in  8  CPU address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_rdata`  out  8  read data to CPU.
- `cpu_stall`  out  1  high: CPU must hold all state this cycle.
- `ld_req`  in  1  loader transfer valid.
- `ld_we`  in  1  loader transfer is write (1) or read (0).
- `ld_addr`  in  8  loader address.
- `ld_wdata`  in  8  loader write data.
- `ld_gnt`  out  1  loader ready; transfer occurs at an edge where `ld_req & ld_gnt`.
- `ld_rdata`  out  8  registered loader read data.
- `mem_R`  out  1  memory read strobe, active low.
- `mem_W`  out  1  memory write strobe, active low.
- `mem_addr`  out  8  memory address.
- `mem_wdata`  out  8  memory write data.
- `mem_rdata`  in  8  memory read data (combinational from `mem_addr` while `mem_R` low).
- `err`  out  1  sticky: CPU drove `cpu_R` and `cpu_W` low in the same cycle.
- `owner`  out  1  current owner register: 0 CPU, 1 loader.

## Operation
- Owner FSM has two states, CPU_OWN (`owner`=0) and LD_OWN (`owner`=1). Memory-side outputs are a combinational mux selected by the `owner` register.
- **CPU_OWN behaviour**
  - `mem_R`/`mem_W`/`mem_addr`/`mem_wdata` pass through from the CPU port.
  - `cpu_rdata = mem_rdata`.
  - `cpu_stall = 0` and `ld_gnt = 0`.
  - If `cpu_R` and `cpu_W` are both low, both `mem_R` and `mem_W` are forced high (access blocked).
- **LD_OWN behaviour**
  - `cpu_stall = 1`, `ld_gnt = 1`, `cpu_rdata = 0`. CPU strobes are ignored.
  - `mem_addr = ld_addr` and `mem_wdata = ld_wdata`.
  - `mem_R = ~(ld_req & ~ld_we)` and `mem_W = ~(ld_req & ld_we)`.
- **Transitions (evaluated at each rising edge)**
  - CPU_OWN → LD_OWN when `ld_req`=1. The CPU access of that cycle completes at the same edge.
  - LD_OWN → CPU_OWN when `ld_req`=0.
  - LD_OWN → CPU_OWN when a transfer occurs, `burst_cnt == MAX_BURST-1`, and the CPU is pending (`cpu_R`=0 or `cpu_W`=0).
  - Otherwise LD_OWN stays.
- **burst_cnt**
  - Clears on entry to LD_OWN.
  - Increments per transfer and saturates at `MAX_BURST-1`. A CPU access that becomes pending late therefore wins at the next transfer.
  - If the CPU is idle, the loader keeps memory indefinitely.
- After a forced yield the CPU gets exactly one CPU_OWN cycle. The FSM then returns to LD_OWN if `ld_req` is still 1.
- `ld_rdata` loads `mem_rdata` at each loader read transfer edge and holds otherwise.
- `err` sets at any edge where `cpu_R`=0 and `cpu_W`=0, regardless of `owner`. It clears only by reset.

## Timing
- **Reset values:** `owner`=0, `burst_cnt`=0, `err`=0, `ld_rdata`=0. Consequently `ld_gnt`=0 and `cpu_stall`=0, and the memory outputs follow the CPU pass-through.
- **Reset mid-burst:** `owner` returns to CPU asynchronously. No loader transfer is performed while `rst` is low.
- **Loader latency:** the request is seen at edge N. `ld_gnt` rises after edge N, the transfer completes at edge N+1, and read data is valid on `ld_rdata` after edge N+1.
- **Loader throughput:** back-to-back transfers run at 1 per cycle inside LD_OWN.
- **Loader handshake rules:** the loader holds `ld_we`/`ld_addr`/`ld_wdata` stable while `ld_req`=1 until the transfer edge. A new transfer may be presented in the following cycle.
- CPU-path addresses and data are combinational; there is no added latency.
- A stall is visible in the same cycle `owner` becomes 1.
- **Simultaneous events:** `ld_req` rising together with a CPU access in CPU_OWN → the CPU access completes at that edge, and the loader owns memory from the next cycle.

## Test plan
- **Pass-through:** reset, drive `cpu_R`=0 with `cpu_addr`=0x10 and memory[0x10]=0xA5 → `cpu_rdata`=0xA5, `cpu_stall`=0, `owner`=0. Then drive `cpu_W`=0 with data 0x3C → memory[0x10]=0x3C after the edge.
- **Loader single write/read:** `ld_req`=1, `ld_we`=1, addr 0x80, data 0x77 → `ld_gnt` rises one cycle later and memory[0x80]=0x77 after the next edge. Then a read of 0x80 → `ld_rdata`=0x77 one cycle after the transfer edge. `ld_req`=0 → `owner`=0 at the next edge.
- **Fairness, MAX_BURST=4:** loader streams 10 writes to 0x00..0x09 while the CPU holds `cpu_R`=0 → 4 transfers, 1 CPU_OWN cycle with `cpu_stall`=0, 4 transfers, 1 CPU cycle, 2 transfers. Memory contents are correct.
- **Idle CPU:** with `cpu_R`=`cpu_W`=1, loader streams 20 transfers → `owner` stays 1 throughout, with no yield.
- **Collision:** `cpu_R`=0 and `cpu_W`=0 for one cycle → `mem_R`=`mem_W`=1 that cycle, no memory write occurs, and `err`=1 stays set until `rst` is pulsed low.
- **Reset mid-burst:** assert `rst` low mid-cycle during the 2nd of 4 loader writes → `owner`=0 and `ld_gnt`=0 immediately, and that write does not occur. After reset is released, `err`=0 and `ld_rdata`=0.
